dram_sequencer: RTL
===================

# dram_sequencer

Generates RAS/CAS/address-mux timing for the slot-3 main-RAM DRAM array. Arbitrates between Z80 memory cycles, Z80 refresh cycles and an internal forced refresh that runs when the CPU has not refreshed for too long. Sits between the Z80 bus/slot decoder and the RAM array's nRAS/nCAS/row-column mux. It is the sequencing layer above the existing CAS gating logic.

## Interface
- T_RCD, 1: cycles nras is low with mux=row before the column phase
- T_RP, 2: precharge cycles, nras and ncas high, after any access
- T_RAS_REF, 2: minimum nras-low cycles for a refresh
- REF_MAX, 128: maximum cycles between refreshes before a refresh is forced; power of 2, at least 8
- RA_W, 7: refresh row address width
- nclk  in  1  system clock; all state updates on its rising edge
- nreset  in  1  asynchronous active-low reset
- nmreq  in  1  Z80 memory request, active low, synchronous to nclk
- nsltsl3  in  1  slot-3 select, active low
- nrfsh  in  1  Z80 refresh, active low
- nras  out  1  row strobe, active low
- ncas  out  1  column strobe, active low
- mux  out  1  address mux select: 0 = row, 1 = column
- nwait  out  1  Z80 wait request, active low
- ref_force  out  1  1 = array row address comes from ref_addr
- ref_addr  out  RA_W  internal refresh row counter

## Operation
- Request definitions:
  - cpu_req = !nmreq & !nsltsl3 & nrfsh
  - z_ref = !nmreq & !nrfsh, regardless of slot
- All outputs are registered (Moore). States are IDLE, ACT, COL, PRE, RREF and RPRE.
- IDLE: nras=1, ncas=1, mux=0. Transitions are evaluated in this priority order:
  - z_ref -> RREF with ref_force=0.
  - pending -> RREF with ref_force=1.
  - cpu_req -> ACT.
- ACT: nras=0, mux=0. After T_RCD cycles -> COL.
- COL: nras=0, ncas=0, mux=1. Holds while nmreq=0. On nmreq=1 -> PRE.
- PRE: nras=1, ncas=1, mux=0 for T_RP cycles -> IDLE.
- RREF: nras=0, ncas=1. Exits after T_RAS_REF cycles and, for a Z80 refresh, not before nmreq=1. Exit -> RPRE.
- RPRE: T_RP cycles -> IDLE. On entering RPRE from a forced refresh:
  - ref_addr increments modulo 2^RA_W.
  - ref_force clears.
- Watchdog counter, width log2(REF_MAX):
  - Clears on entry to RREF (either source).
  - Otherwise increments and saturates at REF_MAX-1.
  - pending = (count == REF_MAX-1).
- nwait=0 while cpu_req holds and the block is not in ACT or COL, in either case:
  - state is RREF, RPRE or PRE; or
  - state is IDLE and pending.
  - Otherwise nwait=1.
- Boundary cases:
  - z_ref and pending in the same IDLE cycle: the Z80 refresh wins and the counter clears; no forced refresh follows.
  - nsltsl3 rising during COL has no effect; only nmreq ends the cycle.
  - ref_addr wraps from 2^RA_W-1 to 0.
- Reset, asserted at any time including mid-access, asynchronously forces:
  - state IDLE;
  - nras=1, ncas=1, mux=0, nwait=1, ref_force=0;
  - ref_addr=0 and counter=0.

## Timing
- CPU access, request sampled at edge k:
  - nras low after edge k.
  - mux=1 and ncas low after edge k+T_RCD.
  - ncas and nras high one edge after nmreq is sampled high.
- A back-to-back CPU request is accepted no earlier than T_RP+1 edges after COL exits.
- Forced refresh holds the CPU for at least T_RAS_REF+T_RP cycles.
- No combinational input-to-output paths.

## Structure
- Shared header `ram/dram_defs.vh` holds:
  - state encodings (3-bit localparams);
  - default T_RCD, T_RP, T_RAS_REF, REF_MAX and RA_W.
- Sub-module `refresh_watchdog` holds the counter, pending flag and ref_addr. Ports:
  - nclk, nreset, clr, adv, pending, ref_addr.
- The top level holds the FSM and the timing down-counter.

## Test plan
- Reset mid-COL, with nras=0 and ncas=0: assert nreset -> all strobes high immediately, ref_addr=0; after release, state is IDLE.
- CPU read with nmreq=0 and nsltsl3=0 for 4 cycles, defaults:
  - nras low 1 cycle after the request is sampled;
  - mux=1 and ncas low the next cycle;
  - both high 1 cycle after nmreq rises;
  - PRE lasts 2 cycles.
- Request with nsltsl3=1: nras, ncas and nwait stay high throughout.
- Z80 refresh every 100 cycles, nmreq and nrfsh low for 2 cycles: nras low for 2 cycles with ref_force=0; no forced refresh ever occurs.
- No refresh for 127 cycles, then cpu_req held:
  - nwait=0;
  - forced refresh with ref_force=1 and ref_addr=0, then ref_addr=1;
  - CPU access proceeds afterward.
- Same-cycle z_ref and pending: only one refresh occurs, ref_force=0, and ref_addr is unchanged.
- 128 forced refreshes: ref_addr wraps from 127 to 0.

Source files
------------

// File: rtl/dram_sequencer_pkg.sv
// dram_sequencer_pkg
//   Shared definitions for the slot-3 DRAM sequencer: default timing
//   parameters, FSM state encoding and a small sizing helper.
package dram_sequencer_pkg;

  localparam int unsigned T_RCD_DEF     = 1;    // row-to-column delay, cycles
  localparam int unsigned T_RP_DEF      = 2;    // precharge, cycles
  localparam int unsigned T_RAS_REF_DEF = 2;    // minimum refresh nras-low, cycles
  localparam int unsigned REF_MAX_DEF   = 128;  // refresh watchdog period (power of 2)
  localparam int unsigned RA_W_DEF      = 7;    // refresh row address width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACT  = 3'd1,
    ST_COL  = 3'd2,
    ST_PRE  = 3'd3,
    ST_RREF = 3'd4,
    ST_RPRE = 3'd5
  } state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dram_sequencer_if.sv
// dram_sequencer_if
//   Z80-side bus and DRAM strobe bundle for dram_sequencer.
//   master : Z80 / slot decoder side (drives nmreq, nsltsl3, nrfsh)
//   slave  : the sequencer (drives nras, ncas, mux, nwait, ref_force, ref_addr)
//   nmreq, nsltsl3, nrfsh : active-low Z80 request, slot-3 select, refresh
//   nras, ncas            : active-low row/column strobes
//   mux                   : address mux select, 0 = row, 1 = column
//   nwait                 : active-low Z80 wait request
//   ref_force, ref_addr   : array row address override and refresh row
interface dram_sequencer_if
  import dram_sequencer_pkg::*;
#(
  parameter int unsigned RA_W = RA_W_DEF
);

  logic            nmreq;
  logic            nsltsl3;
  logic            nrfsh;
  logic            nras;
  logic            ncas;
  logic            mux;
  logic            nwait;
  logic            ref_force;
  logic [RA_W-1:0] ref_addr;

  modport master (
    output nmreq, nsltsl3, nrfsh,
    input  nras, ncas, mux, nwait, ref_force, ref_addr
  );

  modport slave (
    input  nmreq, nsltsl3, nrfsh,
    output nras, ncas, mux, nwait, ref_force, ref_addr
  );

endinterface

// File: rtl/dram_sequencer_watchdog.sv
// refresh_watchdog
//   Counts cycles since the last refresh and owns the refresh row counter.
//   nclk     : system clock, rising edge
//   nreset   : asynchronous active-low reset
//   clr      : clear the cycle counter (a refresh is starting)
//   adv      : advance ref_addr by one row (a forced refresh completed)
//   pending  : counter has saturated, a forced refresh is due
//   ref_addr : refresh row address, wraps modulo 2^RA_W
module refresh_watchdog
  import dram_sequencer_pkg::*;
#(
  parameter int unsigned REF_MAX = REF_MAX_DEF,
  parameter int unsigned RA_W    = RA_W_DEF
) (
  input  logic            nclk,
  input  logic            nreset,
  input  logic            clr,
  input  logic            adv,
  output logic            pending,
  output logic [RA_W-1:0] ref_addr
);

  localparam int unsigned     CNT_W   = $clog2(REF_MAX);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(REF_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RA_W-1:0]  addr_q, addr_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    addr_d = adv ? (addr_q + RA_W'(1)) : addr_q;
  end

  always_ff @(posedge nclk or negedge nreset) begin
    if (!nreset) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

  assign pending  = (cnt_q == CNT_TOP);
  assign ref_addr = addr_q;

endmodule

// File: rtl/dram_sequencer.sv
// dram_sequencer
//   RAS/CAS/address-mux sequencer for the slot-3 main-RAM DRAM array.
//   Arbitrates Z80 memory cycles, Z80 refresh cycles and an internally
//   forced refresh when the CPU has not refreshed for REF_MAX cycles.
//   nclk   : system clock, rising edge
//   nreset : asynchronous active-low reset
//   bus    : dram_sequencer_if.slave (Z80 requests in, DRAM strobes out)
//   All outputs are registered; there is no input-to-output combinational path.
module dram_sequencer
  import dram_sequencer_pkg::*;
#(
  parameter int unsigned T_RCD     = T_RCD_DEF,
  parameter int unsigned T_RP      = T_RP_DEF,
  parameter int unsigned T_RAS_REF = T_RAS_REF_DEF,
  parameter int unsigned REF_MAX   = REF_MAX_DEF,
  parameter int unsigned RA_W      = RA_W_DEF
) (
  input  logic          nclk,
  input  logic          nreset,
  dram_sequencer_if.slave bus
);

  localparam int unsigned TMR_W = $clog2(max3(T_RCD, T_RP, T_RAS_REF) + 1);

  // Timer holds "cycles remaining minus one" for the current timed state.
  localparam logic [TMR_W-1:0] LD_RCD = TMR_W'(T_RCD - 1);
  localparam logic [TMR_W-1:0] LD_RP  = TMR_W'(T_RP - 1);
  localparam logic [TMR_W-1:0] LD_RAS = TMR_W'(T_RAS_REF - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             nras_q, nras_d;
  logic             ncas_q, ncas_d;
  logic             mux_q, mux_d;
  logic             nwait_q, nwait_d;
  logic             ref_force_q, ref_force_d;

  logic            cpu_req;
  logic            z_ref;
  logic            tmr_done;
  logic            wd_clr;
  logic            wd_adv;
  logic            pending;
  logic [RA_W-1:0] ref_addr;

  assign cpu_req  = !bus.nmreq && !bus.nsltsl3 && bus.nrfsh;
  assign z_ref    = !bus.nmreq && !bus.nrfsh;
  assign tmr_done = (tmr_q == '0);

  refresh_watchdog #(
    .REF_MAX (REF_MAX),
    .RA_W    (RA_W)
  ) u_watchdog (
    .nclk     (nclk),
    .nreset   (nreset),
    .clr      (wd_clr),
    .adv      (wd_adv),
    .pending  (pending),
    .ref_addr (ref_addr)
  );

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    ref_force_d = ref_force_q;
    wd_adv      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Z80 refresh beats a pending forced refresh; both clear the watchdog.
        if (z_ref) begin
          state_d     = ST_RREF;
          tmr_d       = LD_RAS;
          ref_force_d = 1'b0;
        end else if (pending) begin
          state_d     = ST_RREF;
          tmr_d       = LD_RAS;
          ref_force_d = 1'b1;
        end else if (cpu_req) begin
          state_d = ST_ACT;
          tmr_d   = LD_RCD;
        end
      end
      ST_ACT: begin
        if (tmr_done) state_d = ST_COL;
        else          tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_COL: begin
        // Only nmreq ends the column phase; slot select is ignored here.
        if (bus.nmreq) begin
          state_d = ST_PRE;
          tmr_d   = LD_RP;
        end
      end
      ST_PRE, ST_RPRE: begin
        if (tmr_done) state_d = ST_IDLE;
        else          tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_RREF: begin
        if (!tmr_done) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (ref_force_q || bus.nmreq) begin
          state_d     = ST_RPRE;
          tmr_d       = LD_RP;
          wd_adv      = ref_force_q;
          ref_force_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        tmr_d       = '0;
        ref_force_d = 1'b0;
      end
    endcase

    wd_clr = (state_d == ST_RREF) && (state_q != ST_RREF);

    // Strobes are decoded from the next state so they change on the same
    // edge as the state register.
    nras_d  = !(state_d inside {ST_ACT, ST_COL, ST_RREF});
    ncas_d  = (state_d != ST_COL);
    mux_d   = (state_d == ST_COL);
    nwait_d = !(cpu_req &&
                ((state_d inside {ST_PRE, ST_RREF, ST_RPRE}) ||
                 ((state_d == ST_IDLE) && pending)));
  end

  always_ff @(posedge nclk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      nras_q      <= 1'b1;
      ncas_q      <= 1'b1;
      mux_q       <= 1'b0;
      nwait_q     <= 1'b1;
      ref_force_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      nras_q      <= nras_d;
      ncas_q      <= ncas_d;
      mux_q       <= mux_d;
      nwait_q     <= nwait_d;
      ref_force_q <= ref_force_d;
    end
  end

  assign bus.nras      = nras_q;
  assign bus.ncas      = ncas_q;
  assign bus.mux       = mux_q;
  assign bus.nwait     = nwait_q;
  assign bus.ref_force = ref_force_q;
  assign bus.ref_addr  = ref_addr;

endmodule
